// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial sequence detector:
// parameter limits, the power-on pattern helper and the detection mode enum.
package seq_det_pkg;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;
  localparam int CNT_W_MAX = 16;

  // Overlapping detection keeps the fill count after a match so the tail of
  // one occurrence can start the next; non-overlapping demands fresh bits.
  typedef enum logic {
    NON_OVERLAP = 1'b0,
    OVERLAP     = 1'b1
  } mode_e;

  // All-ones pattern of the requested width; width 3 gives the classic "111".
  function automatic logic [PAT_W_MAX-1:0] default_pattern(input int width);
    logic [PAT_W_MAX-1:0] p;
    p = '0;
    for (int i = 0; i < PAT_W_MAX; i++) begin
      if (i < width) p[i] = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// History shift register and saturating fill counter for seq_detector_prog.
// Only PAT_W-1 past bits are stored: the full PAT_W-bit window is always the
// stored bits followed by the bit currently on bit_in, which is exactly the
// "next history" the top level compares against the pattern.
module seq_det_hist #(
  parameter int PAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift,
  input  logic             fill_rst,
  input  logic             bit_in,
  output logic [PAT_W-1:0] hist,
  output logic             fill_ok
);

  localparam int             FW        = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]  FILL_MAX  = FW'(PAT_W);
  localparam logic [FW-1:0]  FILL_NEED = FW'(PAT_W - 1);

  logic [PAT_W-2:0] hist_q;
  logic [FW-1:0]    fill_q;

  assign hist    = {hist_q, bit_in};
  assign fill_ok = (fill_q >= FILL_NEED);

  // Clear wins over shift; a non-overlap match restarts the fill count while
  // still shifting the matching bit in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clr) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift) begin
      hist_q <= hist[PAT_W-2:0];
      if (fill_rst) begin
        fill_q <= '0;
      end else if (fill_q != FILL_MAX) begin
        fill_q <= fill_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Run-time programmable serial sequence detector with registered match pulse
// and saturating match counter.
// Optional feature: define SEQ_DET_MASK_EN to add pat_mask_in, a per-bit
// don't-care mask loaded alongside the pattern.
import seq_det_pkg::*;

module seq_detector_prog #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] pat_mask_in,
`endif
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [PAT_W_MAX-1:0] DEF_FULL = default_pattern(PAT_W);
  localparam logic [PAT_W-1:0]     DEF_PAT  = DEF_FULL[PAT_W-1:0];
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

  // Reject widths outside the supported range at elaboration time.
  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX || CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_params
    $error("seq_detector_prog: PAT_W or CNT_W out of range");
  end

  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] hist;
  logic             fill_ok;
  logic             sample;
  logic             hit;
  mode_e            mode;

  assign mode   = mode_e'(overlap);
  assign sample = in_valid & ~pat_load;

`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0] mask;

  // Mask register follows the pattern register: all ones after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '1;
    end else if (pat_load) begin
      mask <= pat_mask_in;
    end
  end

  assign hit = sample & fill_ok & (((hist ^ pat) & mask) == '0);
`else
  assign hit = sample & fill_ok & (hist == pat);
`endif

  seq_det_hist #(
    .PAT_W(PAT_W)
  ) u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (pat_load),
    .shift   (sample),
    .fill_rst(hit & (mode == NON_OVERLAP)),
    .bit_in  (in),
    .hist    (hist),
    .fill_ok (fill_ok)
  );

  // Pattern register: all ones out of reset, replaced on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat <= DEF_PAT;
    end else if (pat_load) begin
      pat <= pat_in;
    end
  end

  // Registered match pulse; hit is already low on loads and invalid cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 1'b0;
    end else begin
      out <= hit;
    end
  end

  // Saturating match counter; an explicit clear beats a coincident match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (hit && match_cnt != CNT_MAX) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Parametrised, run-time-programmable serial sequence detector; successor to the fixed "111" detector.
- Samples one bit per qualified clock and compares the last PAT_W bits against a loadable pattern.
- Raises a one-cycle registered match pulse. Supports overlapping and non-overlapping detection and keeps a saturating match counter.
- Sits on serial bit streams (line decoders, framing/sync-word search) ahead of byte-level logic.

Parameters:
- PAT_W, 3, pattern length in bits; legal range 2..16.
- CNT_W, 8, width of the saturating match counter; legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies `in`; the bit is sampled only when high.
- in  input  1  serial data bit.
- pat_load  input  1  when high, loads `pat_in` into the pattern register.
- pat_in  input  PAT_W  new pattern; bit PAT_W-1 is the first bit received in time.
- overlap  input  1  1 = overlapping detection; 0 = non-overlapping.
- cnt_clr  input  1  synchronous clear of `match_cnt`.
- out  output  1  registered match pulse.
- match_cnt  output  CNT_W  saturating count of matches.

Behaviour:
- Reset (rst_n low, asynchronous): pattern register = all ones (PAT_W=3 reproduces "111" detection); history = 0; fill = 0; out = 0; match_cnt = 0.
- Sampling (rising edge with in_valid=1 and pat_load=0):
  - next history = {hist[PAT_W-2:0], in}.
  - fill increments and saturates at PAT_W.
- Match condition: (fill >= PAT_W-1 before the shift) AND (next history == pattern).
  - Only bits received since the last reset/load/non-overlap clear are used; stale history never matches.
- out is registered: it is high for exactly the one cycle following the edge that samples the last pattern bit. Latency: 0 cycles after the sampling edge (same as the 111 detector).
- out = 0 on any edge where in_valid=0. Gaps in in_valid are transparent: history is held, not cleared.
- Overlap mode:
  - overlap=1: fill is kept after a match. With pattern 111, stream 1111 matches at bits 3 and 4.
  - overlap=0: fill is reset to 0 on the match edge, so the next match needs PAT_W fresh bits.
  - overlap is sampled on each edge; changing it mid-stream affects only future matches.
- pat_load=1: the pattern register takes pat_in, history and fill are cleared, out = 0.
  - A bit presented on the same edge (in_valid=1) is discarded; load wins.
- match_cnt:
  - Increments by 1 on each edge where out is set.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr=1 forces 0; clear wins over a simultaneous match, and out still pulses.
- Reset mid-operation: all partial history is lost, and the pattern returns to all ones (a loaded pattern is not retained).
- No combinational path from any input to any output.

Optional Feature:
- Macro: SEQ_DET_MASK_EN.
- Defined:
  - Adds input pat_mask_in [PAT_W-1:0], loaded together with pat_in on pat_load. Its reset value is all ones.
  - Bit positions with mask=0 are don't-care in the comparison: (next history ^ pattern) & mask == 0.
  - The fill requirement is unchanged.
- Undefined: the port is absent and the comparison is an exact equality. The pattern register, counter and timing are identical in both builds.

Decomposition:
- Package seq_det_pkg:
  - PAT_W_MIN=2, PAT_W_MAX=16, CNT_W_MAX=16.
  - Default-pattern function returning all ones for a given width.
  - Mode enum: OVERLAP=1'b1, NON_OVERLAP=1'b0.
- One natural sub-module, seq_det_hist: holds the history shift register and the saturating fill counter, with clear/shift controls, and outputs hist and a fill_ok flag.
- The top level owns the pattern/mask registers, the comparison, out, and match_cnt.

Test Plan:
- Defaults (PAT_W=3), no load, overlap=1, in_valid=1, stream 1,1,1,1,1 -> out high after bits 3, 4 and 5; match_cnt=3.
- Same stream with overlap=0, extended to 6 bits -> out after bits 3 and 6 only; match_cnt=2.
- pat_load with pat_in=3'b101, overlap=1, stream 1,0,1,0,1 -> out after bits 3 and 5. A bit presented on the load edge is ignored: no match counted from it.
- Stream 1,1 then rst_n pulsed low mid-cycle, then a single 1 -> out stays 0; match_cnt=0 immediately at reset assertion; pattern back to 111.
- in_valid gaps: 1, (gap x3), 1, (gap), 1 -> exactly one out pulse, on the edge sampling the third valid 1; out=0 during gaps.
- CNT_W=2, overlap=1, eight consecutive 1s (6 matches) -> match_cnt saturates at 3. cnt_clr coincident with the next match -> match_cnt=0 and out still high. With SEQ_DET_MASK_EN, pattern 101 and mask 101, stream 1,1,1 -> match.
